// File: rtl/udp_fragment_buffer.sv
// Single-slot UDP fragment reassembly buffer: captures one packet, then drains it over valid/ready.
// Optional capture-stall timeout is built when UDP_FRAGMENT_TIMEOUT_EN is defined.
module udp_fragment_buffer #(
  parameter int DATA_WIDTH     = 8,
  parameter int DEPTH          = 4096,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [DATA_WIDTH-1:0]      in_data,
  input  logic                       in_valid,
  input  logic                       in_last,
  input  logic [15:0]                fragment_id,
  input  logic                       out_ready,
  output logic                       slot_ready,
  output logic                       packet_ready,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic                       out_first,
  output logic                       out_last,
  output logic                       out_valid,
  output logic [15:0]                current_packet_id,
  output logic [$clog2(DEPTH):0]     beat_count,
  output logic                       overflow_error,
  output logic                       timeout_error
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int MW = DATA_WIDTH + 2;

  if (DEPTH < 4 || (1 << AW) != DEPTH) begin : g_bad_depth
    $error("DEPTH must be a power of two and at least 4");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DISCARD, S_DRAIN} state_t;
  state_t state, state_next;

  logic [MW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] rd_cnt;
  logic [MW-1:0] rd_word_p1;
  logic          vld_p1;

  logic wr_en, wr_first, ovf_hit, tmo_hit, tmo_expire;
  logic full, adv, issue, drain_done;

  assign full       = (beat_count == CW'(DEPTH));
  assign adv        = !out_valid || out_ready;
  assign issue      = (state == S_DRAIN) && adv && (rd_cnt < beat_count);
  assign drain_done = (state == S_DRAIN) && out_valid && out_ready && out_last;

`ifdef UDP_FRAGMENT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] idle_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      idle_cnt <= '0;
    end else if (state != S_CAPTURE || in_valid) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + TW'(1);
    end
  end

  // This idle cycle is the one that brings the count up to TIMEOUT_CYCLES.
  assign tmo_expire = (state == S_CAPTURE) && !in_valid && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_expire = 1'b0;
`endif

  always_comb begin
    state_next = state;
    wr_en      = 1'b0;
    wr_first   = 1'b0;
    ovf_hit    = 1'b0;
    tmo_hit    = 1'b0;
    case (state)
      S_IDLE: if (in_valid) begin
        wr_en      = 1'b1;
        wr_first   = 1'b1;
        state_next = in_last ? S_DRAIN : S_CAPTURE;
      end
      S_CAPTURE: if (in_valid) begin
        if (full) begin
          ovf_hit    = 1'b1;
          state_next = in_last ? S_IDLE : S_DISCARD;
        end else begin
          wr_en = 1'b1;
          if (in_last) state_next = S_DRAIN;
        end
      end else if (tmo_expire) begin
        tmo_hit    = 1'b1;
        state_next = S_IDLE;
      end
      S_DISCARD: if (in_valid && in_last) state_next = S_IDLE;
      S_DRAIN:   if (drain_done) state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state             <= S_IDLE;
      slot_ready        <= 1'b0;
      packet_ready      <= 1'b0;
      overflow_error    <= 1'b0;
      timeout_error     <= 1'b0;
      current_packet_id <= '0;
      beat_count        <= '0;
      wr_ptr            <= '0;
      rd_cnt            <= '0;
      vld_p1            <= 1'b0;
      out_valid         <= 1'b0;
      out_data          <= '0;
      out_first         <= 1'b0;
      out_last          <= 1'b0;
    end else begin
      state          <= state_next;
      slot_ready     <= (state_next == S_IDLE);
      packet_ready   <= (state_next == S_DRAIN);
      overflow_error <= ovf_hit;
      timeout_error  <= tmo_hit;
      if (state == S_IDLE) current_packet_id <= fragment_id;
      if (wr_en) begin
        wr_ptr     <= wr_ptr + AW'(1);
        beat_count <= wr_first ? CW'(1) : beat_count + CW'(1);
      end
      // Drain pipeline: memory read (p1) feeds the output register; both freeze on a stall.
      if (state == S_DRAIN && adv) begin
        vld_p1    <= issue;
        if (issue) rd_cnt <= rd_cnt + CW'(1);
        out_valid <= vld_p1;
        out_data  <= rd_word_p1[DATA_WIDTH-1:0];
        out_first <= rd_word_p1[MW-1];
        out_last  <= rd_word_p1[MW-2];
      end
      if (ovf_hit || tmo_hit || drain_done) begin
        wr_ptr     <= '0;
        rd_cnt     <= '0;
        beat_count <= '0;
        vld_p1     <= 1'b0;
        out_valid  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr] <= {wr_first, in_last, in_data};
    if (issue) rd_word_p1 <= mem[rd_cnt[AW-1:0]];
  end
endmodule

// File: tb/tb_udp_fragment_buffer.sv
// Randomized self-checking bench for udp_fragment_buffer (DEPTH=16, TIMEOUT_CYCLES=8).
// The reference model is a queue of packet bytes; expected output follows from packet length alone.
module tb_udp_fragment_buffer;
  localparam int DW = 8;
  localparam int DEPTH = 16;
  localparam int TMO = 8;
  localparam int CW = $clog2(DEPTH) + 1;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic [15:0]   fragment_id = '0;
  logic          out_ready = 1'b0;
  logic          slot_ready, packet_ready, out_first, out_last, out_valid;
  logic [DW-1:0] out_data;
  logic [15:0]   current_packet_id;
  logic [CW-1:0] beat_count;
  logic          overflow_error, timeout_error;

  udp_fragment_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .fragment_id(fragment_id), .out_ready(out_ready), .slot_ready(slot_ready),
    .packet_ready(packet_ready), .out_data(out_data), .out_first(out_first), .out_last(out_last),
    .out_valid(out_valid), .current_packet_id(current_packet_id), .beat_count(beat_count),
    .overflow_error(overflow_error), .timeout_error(timeout_error)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;
  logic [DW-1:0] pkt[$];
  int ovf_cnt, ovf_at, consumed;
  bit ov_seen;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic watch;
    if (overflow_error) begin ovf_cnt++; ovf_at = consumed; end
    if (out_valid) ov_seen = 1'b1;
  endtask

  task automatic send_pkt(input logic [15:0] id, input int gap_max);
    int n;
    n = pkt.size();
    ovf_cnt = 0; ovf_at = 0; consumed = 0; ov_seen = 1'b0;
    tests++;
    if (slot_ready !== 1'b1) begin
      fails++; $display("FAIL send_slot_ready: got %b want 1", slot_ready);
    end
    fragment_id = id;
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        repeat ($urandom_range(gap_max, 0)) begin
          in_valid = 1'b0; in_last = 1'($urandom); in_data = DW'($urandom);
          tick; watch;
        end
      end
      in_valid = 1'b1; in_data = pkt[i]; in_last = (i == n - 1);
      tick; consumed++; watch;
      if (i == 0) fragment_id = 16'($urandom);
    end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic drain_pkt(input logic [15:0] id, input int mode);
    int n, first_k, acc_first, acc_last;
    bit rdy, prev_stall;
    logic [DW+1:0] prev_word;
    logic [DW+1:0] got[$];
    n = pkt.size(); first_k = -1; acc_first = -1; acc_last = -1; prev_stall = 1'b0; prev_word = '0;
    for (int k = 0; k < 400 && got.size() < n; k++) begin
      if (k == 0) begin
        tests++;
        if (packet_ready !== 1'b1 || beat_count !== CW'(n) || current_packet_id !== id) begin
          fails++;
          $display("FAIL drain_start: packet_ready=%b beat_count=%0d id=%h want 1/%0d/%h",
                   packet_ready, beat_count, current_packet_id, n, id);
        end
      end
      if (prev_stall) begin
        tests++;
        if (out_valid !== 1'b1 || {out_first, out_last, out_data} !== prev_word) begin
          fails++;
          $display("FAIL stall_hold: valid=%b word=%h want 1/%h", out_valid,
                   {out_first, out_last, out_data}, prev_word);
        end
      end
      if (out_valid === 1'b1 && first_k < 0) first_k = k;
      case (mode)
        0: rdy = 1'b1;
        1: rdy = 1'($urandom);
        default: rdy = (k % 4 == 0) || (k % 4 == 3);
      endcase
      out_ready = rdy;
      in_valid = 1'($urandom); in_last = 1'($urandom); in_data = DW'($urandom);
      if (out_valid === 1'b1 && rdy) begin
        got.push_back({out_first, out_last, out_data});
        if (acc_first < 0) acc_first = k;
        acc_last = k;
      end
      prev_stall = (out_valid === 1'b1) && !rdy;
      prev_word = {out_first, out_last, out_data};
      tick;
    end
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    tests++;
    if (first_k != 2) begin fails++; $display("FAIL out_valid_latency: got %0d want 2", first_k); end
    tests++;
    if (got.size() != n) begin fails++; $display("FAIL drain_count: got %0d want %0d", got.size(), n); end
    for (int j = 0; j < n && j < got.size(); j++) begin
      tests++;
      if (got[j] !== {(j == 0), (j == n - 1), pkt[j]}) begin
        fails++;
        $display("FAIL beat[%0d]: got %h want %h", j, got[j], {(j == 0), (j == n - 1), pkt[j]});
      end
    end
    if (mode == 0) begin
      tests++;
      if (acc_last - acc_first != n - 1) begin
        fails++; $display("FAIL throughput: span %0d want %0d", acc_last - acc_first, n - 1);
      end
    end
    tests++;
    if (slot_ready !== 1'b1 || out_valid !== 1'b0 || packet_ready !== 1'b0 || beat_count !== '0) begin
      fails++;
      $display("FAIL drain_end: slot=%b valid=%b pr=%b bc=%0d want 1/0/0/0",
               slot_ready, out_valid, packet_ready, beat_count);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) tick;
    tests++;
    if ({slot_ready, packet_ready, out_valid, out_first, out_last, out_data, current_packet_id,
         beat_count, overflow_error, timeout_error} !== '0) begin
      fails++; $display("FAIL reset_outputs: slot=%b pr=%b valid=%b bc=%0d want all 0",
                        slot_ready, packet_ready, out_valid, beat_count);
    end
    reset_n = 1'b1;
    #1;
    tests++;
    if (slot_ready !== 1'b0) begin fails++; $display("FAIL slot_after_release: got %b want 0", slot_ready); end
    tick;
    tests++;
    if (slot_ready !== 1'b1) begin fails++; $display("FAIL slot_rise: got %b want 1", slot_ready); end
  endtask

  task automatic test_basic;
    pkt = {8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
    send_pkt(16'h1234, 0);
    drain_pkt(16'h1234, 0);
  endtask

  task automatic test_single_beat;
    pkt = {8'h5A};
    send_pkt(16'h00C3, 0);
    drain_pkt(16'h00C3, 0);
  endtask

  task automatic test_overflow;
    pkt.delete();
    for (int i = 0; i < 20; i++) pkt.push_back(DW'($urandom));
    send_pkt(16'hBEEF, 2);
    tests++;
    if (ovf_cnt != 1 || ovf_at != DEPTH + 1) begin
      fails++; $display("FAIL overflow_pulse: count=%0d at beat %0d want 1 at %0d", ovf_cnt, ovf_at, DEPTH + 1);
    end
    tests++;
    if (ov_seen || slot_ready !== 1'b1) begin
      fails++; $display("FAIL overflow_recover: out_valid_seen=%b slot=%b want 0/1", ov_seen, slot_ready);
    end
  endtask

  task automatic test_stall_pattern;
    pkt.delete();
    for (int i = 0; i < 7; i++) pkt.push_back(DW'($urandom));
    send_pkt(16'h0042, 1);
    drain_pkt(16'h0042, 2);
  endtask

  task automatic test_timeout;
    int lat;
    pkt = {8'h11, 8'h22, 8'h33};
    fragment_id = 16'h0777;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = pkt[i]; in_last = 1'b0; tick;
    end
    in_valid = 1'b0;
`ifdef UDP_FRAGMENT_TIMEOUT_EN
    lat = -1;
    for (int i = 1; i <= 30 && lat < 0; i++) begin
      tick;
      if (timeout_error === 1'b1) lat = i;
    end
    tests++;
    if (lat != TMO || slot_ready !== 1'b1) begin
      fails++; $display("FAIL timeout_latency: got %0d slot=%b want %0d/1", lat, slot_ready, TMO);
    end
    tick;
    tests++;
    if (timeout_error !== 1'b0 || beat_count !== '0) begin
      fails++; $display("FAIL timeout_pulse: te=%b bc=%0d want 0/0", timeout_error, beat_count);
    end
`else
    lat = 0;
    repeat (30) begin tick; if (timeout_error !== 1'b0) lat++; end
    tests++;
    if (lat != 0 || slot_ready !== 1'b0) begin
      fails++; $display("FAIL no_timeout: pulses=%0d slot=%b want 0/0", lat, slot_ready);
    end
    in_valid = 1'b1; in_data = 8'h44; in_last = 1'b1; tick;
    in_valid = 1'b0; in_last = 1'b0;
    pkt.push_back(8'h44);
    drain_pkt(16'h0777, 0);
`endif
  endtask

  task automatic test_reset_mid_drain;
    pkt.delete();
    for (int i = 0; i < 10; i++) pkt.push_back(DW'($urandom));
    send_pkt(16'h0A0A, 0);
    out_ready = 1'b1;
    repeat (4) tick;
    #2 reset_n = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0 || packet_ready !== 1'b0 || beat_count !== '0 || slot_ready !== 1'b0) begin
      fails++; $display("FAIL reset_mid_drain: valid=%b pr=%b bc=%0d slot=%b want 0/0/0/0",
                        out_valid, packet_ready, beat_count, slot_ready);
    end
    out_ready = 1'b0;
    tick;
    reset_n = 1'b1;
    tick;
    tests++;
    if (slot_ready !== 1'b1 || overflow_error !== 1'b0 || timeout_error !== 1'b0) begin
      fails++; $display("FAIL after_reset: slot=%b ovf=%b tmo=%b want 1/0/0",
                        slot_ready, overflow_error, timeout_error);
    end
    pkt = {8'hC0, 8'hC1, 8'hC2, 8'hC3};
    send_pkt(16'h0B0B, 0);
    drain_pkt(16'h0B0B, 0);
  endtask

  task automatic test_random;
    for (int p = 0; p < 14; p++) begin
      int n;
      logic [15:0] id;
      n = (p == 0) ? DEPTH : $urandom_range(DEPTH, 1);
      id = 16'($urandom);
      pkt.delete();
      for (int i = 0; i < n; i++) pkt.push_back(DW'($urandom));
      send_pkt(id, 2);
      drain_pkt(id, $urandom_range(2, 0));
    end
  endtask

  task automatic test_back_to_back;
    for (int p = 0; p < 2; p++) begin
      pkt.delete();
      for (int i = 0; i < 6; i++) pkt.push_back(DW'($urandom));
      send_pkt(16'h2000 + 16'(p), 0);
      drain_pkt(16'h2000 + 16'(p), 0);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_single_beat;
    test_overflow;
    test_stall_pattern;
    test_timeout;
    test_reset_mid_drain;
    test_random;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
